// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared definitions for the exception controller slice:
//   - CP0 register addresses (status/cause/epc)
//   - ExcCode values for the supported events
//   - status/cause field bit positions
//   - FSM state enum
//   - helpers that pack the architectural status/cause words
// No ports (package).
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ENTER,
    ST_HANDLER,
    ST_LEAVE
  } state_t;

  function automatic logic [31:0] pack_status(input logic [5:0] im,
                                              input logic       exl,
                                              input logic       ie);
    logic [31:0] v;
    v                       = '0;
    v[STATUS_IM_LO +: 6]    = im;
    v[STATUS_EXL]           = exl;
    v[STATUS_IE]            = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic [5:0] ip,
                                             input logic [4:0] exccode);
    logic [31:0] v;
    v                       = '0;
    v[CAUSE_IP_LO  +: 6]    = ip;
    v[CAUSE_EXC_LO +: 5]    = exccode;
    return v;
  endfunction

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// Two-flop synchronizer for the external interrupt lines. Only instantiated
// when EXC_CTRL_IRQ_SYNC_EN is defined.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset, clears both flop stages
//   i_async  in   6 raw interrupt lines
//   o_sync   out  6 synchronized lines (two-cycle latency)
// -----------------------------------------------------------------------------
module irq_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_async,
  output logic [5:0] o_sync
);

  logic [5:0] r_meta;
  logic [5:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// CP0-style exception/interrupt controller. Holds status, cause and epc,
// arbitrates the committing instruction's events, and produces a one-cycle
// redirect/flush pulse on handler entry (to HANDLER_VEC) and on ERET (to epc).
// Optional build macro: EXC_CTRL_IRQ_SYNC_EN -- routes int_req through a
// 2-flop synchronizer (irq_sync) before it reaches cause.IP.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   pc, pc_valid            committing instruction and its valid
//   exc_sys/exc_ri/exc_ov   exceptions of the committing instruction
//   eret                    committing instruction is ERET
//   int_req[5:0]            level-sensitive interrupt lines
//   cp0_we/addr/wdata       MTC0 write port
//   cp0_rdata               combinational MFC0 read of cp0_addr
//   redirect, redirect_pc   fetch restart pulse and target
//   flush                   same as redirect
//   exl                     status.EXL
// -----------------------------------------------------------------------------
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        exc_sys,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        eret,
  input  logic [5:0]  int_req,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        exl
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic [5:0]  w_ip;
  logic        w_int_pend;
  logic        w_any_evt;
  logic [4:0]  w_exccode;
  logic        w_take_exc;
  logic        w_take_eret;

  // Only the IM/EXL/IE bits of an MTC0 write are stored.
  logic        w_unused_wdata;
  assign w_unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2]};

`ifdef EXC_CTRL_IRQ_SYNC_EN
  irq_sync u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (int_req),
    .o_sync  (w_ip)
  );
`else
  assign w_ip = int_req;
`endif

  assign w_int_pend = (|(w_ip & r_im)) && r_ie && !r_exl;
  assign w_any_evt  = w_int_pend | exc_ri | exc_ov | exc_sys;

  // Priority: interrupt > reserved instruction > overflow > syscall.
  always_comb begin
    w_exccode = EXC_SYS;
    if (w_int_pend)  w_exccode = EXC_INT;
    else if (exc_ri) w_exccode = EXC_RI;
    else if (exc_ov) w_exccode = EXC_OV;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // ENTER/LEAVE ignore the commit interface; they only emit the pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_take_exc  = 1'b0;
    w_take_eret = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (r_state)
      ST_RUN: begin
        if (pc_valid && w_any_evt) begin
          w_take_exc  = 1'b1;
          w_state_nxt = ST_ENTER;
        end
      end
      ST_ENTER: begin
        redirect    = 1'b1;
        redirect_pc = HANDLER_VEC;
        w_state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (pc_valid && w_any_evt) begin
          w_take_exc  = 1'b1;
          w_state_nxt = ST_ENTER;
        end else if (pc_valid && eret && r_exl) begin
          // An ERET seen after software cleared EXL is a no-op.
          w_take_eret = 1'b1;
          w_state_nxt = ST_LEAVE;
        end
      end
      ST_LEAVE: begin
        redirect    = 1'b1;
        redirect_pc = r_epc;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign flush = redirect;
  assign exl   = r_exl;

  // MTC0 first; a same-edge event or ERET then overrides the fields it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          CP0_STATUS: begin
            r_im  <= cp0_wdata[STATUS_IM_LO +: 6];
            r_exl <= cp0_wdata[STATUS_EXL];
            r_ie  <= cp0_wdata[STATUS_IE];
          end
          CP0_EPC: r_epc <= cp0_wdata;
          default: ;
        endcase
      end
      if (w_take_exc) begin
        // Nested exceptions keep the original return address.
        if (!r_exl) r_epc <= pc;
        r_exccode <= w_exccode;
        r_exl     <= 1'b1;
      end else if (w_take_eret) begin
        r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_STATUS: cp0_rdata = pack_status(r_im, r_exl, r_ie);
      CP0_CAUSE:  cp0_rdata = pack_cause(w_ip, r_exccode);
      CP0_EPC:    cp0_rdata = r_epc;
      default:    cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl
// Self-checking bench for exc_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0800;
`ifdef EXC_CTRL_IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        exc_sys, exc_ri, exc_ov, eret;
  logic [5:0]  int_req;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        exl;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(.HANDLER_VEC(VEC)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid),
    .exc_sys(exc_sys), .exc_ri(exc_ri), .exc_ov(exc_ov), .eret(eret),
    .int_req(int_req), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .exl(exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural registers plus "a redirect is due this
  // cycle" and "we are inside a handler" flags.
  logic [5:0]  m_im;
  logic        m_exl, m_ie;
  int          m_code;
  logic [31:0] m_epc;
  bit          m_busy;        // this cycle is a redirect pulse
  bit          m_in_handler;  // last accepted transfer went into the handler
  logic [5:0]  m_dly [2];     // int_req delay line for the synchronized build

  function automatic logic [5:0] cur_ip();
    if (SYNC_LAT == 0) return int_req;
    return m_dly[1];
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 5'd12) begin
      v[15:10] = m_im; v[1] = m_exl; v[0] = m_ie;
    end else if (a == 5'd13) begin
      v[15:10] = cur_ip(); v[6:2] = m_code[4:0];
    end else if (a == 5'd14) begin
      v = m_epc;
    end
    return v;
  endfunction

  task automatic model_edge();
    logic [5:0] ip;
    bit         pend, ev, old_exl;
    int         code;
    ip = cur_ip();
    if (reset) begin
      m_im = '0; m_exl = 0; m_ie = 0; m_code = 0; m_epc = '0;
      m_busy = 0; m_in_handler = 0;
      m_dly[0] = '0; m_dly[1] = '0;
      return;
    end
    old_exl = m_exl;
    pend = ((ip & m_im) != 6'd0) && m_ie && !m_exl;
    ev   = pend || exc_ri || exc_ov || exc_sys;
    code = pend ? 0 : exc_ri ? 10 : exc_ov ? 12 : 8;
    if (cp0_we && cp0_addr == 5'd12) begin
      m_im = cp0_wdata[15:10]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
    end
    if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata;
    if (m_busy) begin
      m_busy = 0;
    end else if (pc_valid && ev) begin
      if (!old_exl) m_epc = pc;
      m_code = code; m_exl = 1; m_busy = 1; m_in_handler = 1;
    end else if (m_in_handler && pc_valid && eret && old_exl) begin
      m_exl = 0; m_busy = 1; m_in_handler = 0;
    end
    m_dly[1] = m_dly[0];
    m_dly[0] = int_req;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [31:0] epc_exp;
    @(posedge clk);
    model_edge();
    #1;
    epc_exp = m_busy ? (m_in_handler ? VEC : m_epc) : 32'd0;
    chk("redirect",    {31'd0, redirect}, {31'd0, m_busy});
    chk("flush",       {31'd0, flush},    {31'd0, m_busy});
    chk("redirect_pc", redirect_pc,       epc_exp);
    chk("exl",         {31'd0, exl},      {31'd0, m_exl});
    chk("cp0_rdata",   cp0_rdata,         exp_rdata(cp0_addr));
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] expv);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, expv);
    chk({tag, "_model"}, cp0_rdata, exp_rdata(a));
  endtask

  task automatic idle();
    pc_valid = 0; exc_sys = 0; exc_ri = 0; exc_ov = 0; eret = 0; cp0_we = 0;
  endtask

  initial begin
    reset = 1; pc = '0; int_req = '0; cp0_addr = 5'd0; cp0_wdata = '0;
    m_dly[0] = '0; m_dly[1] = '0;
    idle();
    tick(); tick();
    reset = 0;
    tick();
    rd(5'd12, "rst_status", 32'd0);
    rd(5'd13, "rst_cause",  32'd0);
    rd(5'd14, "rst_epc",    32'd0);

    // Syscall at 0x100 enters the handler.
    pc = 32'h100; pc_valid = 1; exc_sys = 1;
    tick();
    chk("sys_redirect", {31'd0, redirect}, 32'd1);
    chk("sys_target",   redirect_pc, 32'h800);
    chk("sys_exl",      {31'd0, exl}, 32'd1);
    idle();
    rd(5'd14, "sys_epc",   32'h100);
    rd(5'd13, "sys_cause", 32'd8 << 2);
    tick();
    chk("enter_one_cycle", {31'd0, redirect}, 32'd0);

    // Nested reserved-instruction exception keeps epc.
    pc = 32'h200; pc_valid = 1; exc_ri = 1;
    tick();
    chk("ri_target", redirect_pc, 32'h800);
    idle();
    rd(5'd14, "ri_epc",   32'h100);
    rd(5'd13, "ri_cause", 32'd10 << 2);
    tick();

    // ERET returns to epc.
    pc = 32'h804; pc_valid = 1; eret = 1;
    tick();
    chk("eret_redirect", {31'd0, redirect}, 32'd1);
    chk("eret_target",   redirect_pc, 32'h100);
    chk("eret_exl",      {31'd0, exl}, 32'd0);
    idle();
    tick();
    chk("leave_one_cycle", {31'd0, redirect}, 32'd0);

    // ERET with EXL clear does nothing.
    pc = 32'h104; pc_valid = 1; eret = 1;
    tick();
    chk("eret_noop", {31'd0, redirect}, 32'd0);
    idle();

    // MTC0/MFC0.
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h300;
    tick();
    idle();
    rd(5'd14, "mfc0_epc", 32'h300);
    rd(5'd5,  "mfc0_addr5", 32'd0);

    // Interrupt beats overflow on the same instruction.
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick();
    idle();
    int_req = 6'd1;
    for (int i = 0; i < SYNC_LAT; i++) tick();
    pc = 32'h400; pc_valid = 1; exc_ov = 1;
    tick();
    chk("irq_redirect", {31'd0, redirect}, 32'd1);
    idle();
    int_req = 6'd0;
    cp0_addr = 5'd13;
    #1;
    chk("irq_code", {27'd0, cp0_rdata[6:2]}, 32'd0);
    rd(5'd14, "irq_epc", 32'h400);
    tick();
    pc_valid = 1; eret = 1;
    tick();
    idle();
    tick();

    // Reset in the ENTER cycle aborts the pulse.
    pc = 32'h500; pc_valid = 1; exc_sys = 1;
    tick();
    chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
    idle();
    reset = 1;
    tick();
    chk("rst_abort", {31'd0, redirect}, 32'd0);
    reset = 0;
    rd(5'd12, "rst2_status", 32'd0);
    rd(5'd13, "rst2_cause",  32'd0);
    rd(5'd14, "rst2_epc",    32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] addrs [4];
      addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14;
      addrs[3] = 5'($urandom_range(0, 31));
      reset     = ($urandom_range(0, 79) == 0);
      pc        = {$urandom_range(0, 32'h3fff), 2'b00};
      pc_valid  = ($urandom_range(0, 1) == 1);
      exc_sys   = ($urandom_range(0, 9) == 0);
      exc_ri    = ($urandom_range(0, 11) == 0);
      exc_ov    = ($urandom_range(0, 11) == 0);
      eret      = ($urandom_range(0, 3) == 0);
      int_req   = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
      cp0_we    = ($urandom_range(0, 7) == 0);
      cp0_addr  = addrs[$urandom_range(0, 3)];
      cp0_wdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
